// File: rtl/cache_maint_ctrl.sv
// Cache maintenance sequencer: walks every set/way of the tag array, writing back
// dirty lines and cleaning or invalidating each line as the latched command asks.
module cache_maint_ctrl #(
  parameter int setNum = 64,
  parameter int wayNum = 4,
  localparam int idxW = $clog2(setNum),
  localparam int wayW = $clog2(wayNum)
) (
  input  logic            clk,
  input  logic            rest,
  input  logic [1:0]      cmd,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic            busy,
  output logic            cache_stall,
  output logic            tag_rd,
  output logic [idxW-1:0] tag_index,
  output logic [wayW-1:0] tag_way,
  input  logic            tag_rd_valid,
  input  logic            tag_rd_dirty,
  output logic            tag_wr,
  output logic            tag_wr_valid,
  output logic            tag_wr_dirty,
  output logic            wb_req,
  input  logic            wb_ack
);

  localparam int lineW = idxW + wayW;
  localparam logic [lineW-1:0] LINE_ONE = lineW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [1:0]       cmd_reg;
  // {index, way} as one counter so the way wraps into the index for free
  logic [lineW-1:0] line_reg;
  logic             line_valid_reg;
  logic             line_dirty_reg;
  logic             busy_reg;
  logic             ready_reg;
  logic             rd_reg;
  logic             wr_reg;
  logic             wr_valid_reg;
  logic             wr_dirty_reg;
  logic             wb_req_reg;

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_reg      <= S_IDLE;
      cmd_reg        <= 2'b00;
      line_reg       <= '0;
      line_valid_reg <= 1'b0;
      line_dirty_reg <= 1'b0;
      busy_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      wr_valid_reg   <= 1'b0;
      wr_dirty_reg   <= 1'b0;
      wb_req_reg     <= 1'b0;
    end else begin
      ready_reg    <= 1'b0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_dirty_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            busy_reg <= 1'b1;
            if (cmd != 2'b00) begin
              cmd_reg   <= cmd;
              line_reg  <= '0;
              rd_reg    <= 1'b1;
              state_reg <= S_READ;
            end else begin
              ready_reg <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end
        S_READ: begin
          state_reg <= S_CHECK;
        end
        S_CHECK: begin
          line_valid_reg <= tag_rd_valid;
          line_dirty_reg <= tag_rd_dirty;
          if (cmd_reg[1] && tag_rd_valid && tag_rd_dirty) begin
            wb_req_reg <= 1'b1;
            state_reg  <= S_WB;
          end else begin
            wr_reg       <= 1'b1;
            wr_valid_reg <= tag_rd_valid & ~cmd_reg[0];
            wr_dirty_reg <= tag_rd_dirty & ~cmd_reg[1] & ~cmd_reg[0];
            state_reg    <= S_UPDATE;
          end
        end
        S_WB: begin
          if (wb_ack) begin
            wb_req_reg   <= 1'b0;
            wr_reg       <= 1'b1;
            wr_valid_reg <= line_valid_reg & ~cmd_reg[0];
            wr_dirty_reg <= line_dirty_reg & ~cmd_reg[1] & ~cmd_reg[0];
            state_reg    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          line_reg <= line_reg + LINE_ONE;
          if (&line_reg) begin
            ready_reg <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            rd_reg    <= 1'b1;
            state_reg <= S_READ;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg   <= 1'b0;
          wb_req_reg <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = ready_reg;
  assign busy         = busy_reg;
  assign cache_stall  = busy_reg;
  assign tag_rd       = rd_reg;
  assign tag_index    = line_reg[lineW-1:wayW];
  assign tag_way      = line_reg[wayW-1:0];
  assign tag_wr       = wr_reg;
  assign tag_wr_valid = wr_valid_reg;
  assign tag_wr_dirty = wr_dirty_reg;
  assign wb_req       = wb_req_reg;

endmodule

// File: tb/tb_cache_maint_ctrl.sv
// Bench for cache_maint_ctrl on a 4-set x 2-way array: a small tag-array model answers
// reads, a scoreboard checks every tag write and writeback request in walk order.
module tb_cache_maint_ctrl;
  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int LINES = SETS * WAYS;

  logic       clk = 1'b0;
  logic       rest = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, busy, cache_stall, tag_rd;
  logic [1:0] tag_index;
  logic [0:0] tag_way;
  logic       tag_rd_valid = 1'b0, tag_rd_dirty = 1'b0;
  logic       tag_wr, tag_wr_valid, tag_wr_dirty, wb_req;
  logic       wb_ack = 1'b0;

  always #5 clk = ~clk;

  cache_maint_ctrl #(.setNum(SETS), .wayNum(WAYS)) dut (
    .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .cache_stall(cache_stall), .tag_rd(tag_rd), .tag_index(tag_index),
    .tag_way(tag_way), .tag_rd_valid(tag_rd_valid), .tag_rd_dirty(tag_rd_dirty),
    .tag_wr(tag_wr), .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty),
    .wb_req(wb_req), .wb_ack(wb_ack)
  );

  // Tag array model: one-cycle read latency, writes land on the strobe edge
  logic [LINES-1:0] mem_v, mem_d, load_v, load_d;
  logic             load_en = 1'b0;
  always @(posedge clk) begin
    if (load_en) begin
      mem_v <= load_v;
      mem_d <= load_d;
    end else if (tag_wr) begin
      mem_v[{tag_index, tag_way}] <= tag_wr_valid;
      mem_d[{tag_index, tag_way}] <= tag_wr_dirty;
    end
    if (tag_rd) begin
      tag_rd_valid <= mem_v[{tag_index, tag_way}];
      tag_rd_dirty <= mem_d[{tag_index, tag_way}];
    end
  end

  // Memory side: ack arrives ack_lat cycles after wb_req first asserts
  int ack_lat = 0;
  int wb_age  = 0;
  always @(negedge clk) begin
    if (wb_req) begin
      wb_ack = (wb_age == ack_lat);
      wb_age++;
    end else begin
      wb_ack = 1'b0;
      wb_age = 0;
    end
  end

  typedef struct packed {
    logic [2:0] line;
    logic       v;
    logic       d;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [2:0] exp_wb_q[$];
  wr_t        e_wr;
  logic [2:0] e_wb;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic       wb_req_d = 1'b0;

  always @(negedge clk) begin
    if (mon_en && tag_wr) begin
      vectors++;
      if (exp_wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL tag_wr_unexpected: got line %0d v=%0b d=%0b, required no write",
                 {tag_index, tag_way}, tag_wr_valid, tag_wr_dirty);
      end else begin
        e_wr = exp_wr_q.pop_front();
        if ({tag_index, tag_way, tag_wr_valid, tag_wr_dirty} !== e_wr) begin
          miscompares++;
          $display("FAIL tag_wr: got line %0d v=%0b d=%0b, required line %0d v=%0b d=%0b",
                   {tag_index, tag_way}, tag_wr_valid, tag_wr_dirty, e_wr.line, e_wr.v, e_wr.d);
        end
      end
    end
    if (mon_en && wb_req && !wb_req_d) begin
      vectors++;
      if (exp_wb_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_req_unexpected: got line %0d, required no writeback", {tag_index, tag_way});
      end else begin
        e_wb = exp_wb_q.pop_front();
        if ({tag_index, tag_way} !== e_wb) begin
          miscompares++;
          $display("FAIL wb_req_line: got line %0d, required line %0d", {tag_index, tag_way}, e_wb);
        end
      end
    end
    wb_req_d = wb_req;
  end

  task automatic set_mem(input logic [LINES-1:0] v, input logic [LINES-1:0] d);
    load_v  = v;
    load_d  = d;
    load_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issues one command (acceptance edge = E0) and records what happens, cycle n = n-th negedge after E0
  task automatic run_walk(input logic [1:0] c, input int lat, input int mid_cyc, input logic [1:0] mid_cmd,
                          input bit abort_wb, output int ready_cyc, output int ready_cnt,
                          output int busy_cyc, output int rd_cnt, output int wr_cnt, output int wb_cyc,
                          output logic [2:0] first_rd, output bit stall_ok, output bit timed_out);
    ready_cyc = 0; ready_cnt = 0; busy_cyc = 0; rd_cnt = 0; wr_cnt = 0; wb_cyc = 0;
    first_rd = 3'b111; stall_ok = 1'b1; timed_out = 1'b1;
    ack_lat = lat;
    if (c != 2'b00) begin
      for (int l = 0; l < LINES; l++) begin
        if (c[1] && mem_v[l] && mem_d[l]) exp_wb_q.push_back(3'(l));
        exp_wr_q.push_back({3'(l), mem_v[l] & ~c[0], mem_d[l] & ~c[1] & ~c[0]});
      end
    end
    cmd = c;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == mid_cyc) cmd = mid_cmd;
      if (busy) busy_cyc++;
      if (busy !== cache_stall) stall_ok = 1'b0;
      if (tag_rd) begin
        if (rd_cnt == 0) first_rd = {tag_index, tag_way};
        rd_cnt++;
      end
      if (tag_wr) wr_cnt++;
      if (wb_req) wb_cyc++;
      if (cmd_ready) begin
        if (ready_cyc == 0) ready_cyc = n;
        ready_cnt++;
        cmd_valid = 1'b0;
      end
      if (abort_wb && wb_req) begin
        timed_out = 1'b0;
        break;
      end
      if (ready_cyc != 0 && n >= ready_cyc + 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    $display("walk cmd=%0d: cmd_ready at E0+%0d, busy %0d cycles, %0d reads, %0d writes, %0d wb cycles",
             c, ready_cyc, busy_cyc, rd_cnt, wr_cnt, wb_cyc);
  endtask

  int ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc;
  logic [2:0] first_rd;
  bit stall_ok, timed_out;

  task automatic test_reset();
    rest = 1'b0;
    cmd = 2'b11;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({cmd_ready, busy, cache_stall, tag_rd, tag_wr, tag_wr_valid, tag_wr_dirty, wb_req, tag_index, tag_way} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %b, required all zero", i,
                 {cmd_ready, busy, cache_stall, tag_rd, tag_wr, tag_wr_valid, tag_wr_dirty, wb_req, tag_index, tag_way});
      end
    end
    cmd_valid = 1'b0;
    cmd = 2'b00;
    rest = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_nop();
    set_mem(8'hFF, 8'hFF);
    run_walk(2'b00, 0, 0, 2'b00, 1'b0, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (ready_cyc !== 1 || ready_cnt !== 1) begin
      miscompares++;
      $display("FAIL nop_ready: got cycle %0d count %0d, required cycle 1 count 1", ready_cyc, ready_cnt);
    end
    vectors++;
    if (busy_cyc !== 1) begin
      miscompares++;
      $display("FAIL nop_busy: got %0d cycles, required 1", busy_cyc);
    end
    vectors++;
    if (rd_cnt + wr_cnt + wb_cyc !== 0) begin
      miscompares++;
      $display("FAIL nop_activity: got rd=%0d wr=%0d wb=%0d, required none", rd_cnt, wr_cnt, wb_cyc);
    end
  endtask

  task automatic test_invalidate();
    set_mem(8'hFF, 8'hFF);
    run_walk(2'b01, 0, 0, 2'b00, 1'b0, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (timed_out || ready_cyc !== 25 || ready_cnt !== 1) begin
      miscompares++;
      $display("FAIL inval_ready: got cycle %0d count %0d, required cycle 25 count 1", ready_cyc, ready_cnt);
    end
    vectors++;
    if (busy_cyc !== 25 || !stall_ok) begin
      miscompares++;
      $display("FAIL inval_busy: got %0d cycles stall_ok=%0b, required 25 and 1", busy_cyc, stall_ok);
    end
    vectors++;
    if (rd_cnt !== 8 || wr_cnt !== 8 || wb_cyc !== 0) begin
      miscompares++;
      $display("FAIL inval_counts: got rd=%0d wr=%0d wb=%0d, required 8 8 0", rd_cnt, wr_cnt, wb_cyc);
    end
    vectors++;
    if (mem_v !== 8'h00 || mem_d !== 8'h00) begin
      miscompares++;
      $display("FAIL inval_array: got v=%h d=%h, required 00 00", mem_v, mem_d);
    end
  endtask

  task automatic test_flush();
    set_mem(8'hF8, 8'h08);
    run_walk(2'b10, 4, 0, 2'b00, 1'b0, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (timed_out || ready_cyc !== 30 || ready_cnt !== 1) begin
      miscompares++;
      $display("FAIL flush_ready: got cycle %0d count %0d, required cycle 30 count 1", ready_cyc, ready_cnt);
    end
    vectors++;
    if (wb_cyc !== 5 || wr_cnt !== 8) begin
      miscompares++;
      $display("FAIL flush_counts: got wb=%0d wr=%0d, required 5 8", wb_cyc, wr_cnt);
    end
    vectors++;
    if (mem_v !== 8'hF8 || mem_d !== 8'h00) begin
      miscompares++;
      $display("FAIL flush_array: got v=%h d=%h, required f8 00", mem_v, mem_d);
    end
  endtask

  task automatic test_flush_inval();
    set_mem(8'hFF, 8'hFF);
    run_walk(2'b11, 0, 10, 2'b01, 1'b0, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (timed_out || ready_cyc !== 33 || ready_cnt !== 1) begin
      miscompares++;
      $display("FAIL flinv_ready: got cycle %0d count %0d, required cycle 33 count 1", ready_cyc, ready_cnt);
    end
    vectors++;
    if (wb_cyc !== 8 || wr_cnt !== 8 || busy_cyc !== 33) begin
      miscompares++;
      $display("FAIL flinv_counts: got wb=%0d wr=%0d busy=%0d, required 8 8 33", wb_cyc, wr_cnt, busy_cyc);
    end
    cmd = 2'b00;
  endtask

  task automatic test_reset_mid_wb();
    set_mem(8'hFF, 8'hFF);
    run_walk(2'b10, 1000, 0, 2'b00, 1'b1, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (timed_out || wb_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midwb_reach: got wb_req=%b timed_out=%0b, required wb_req 1", wb_req, timed_out);
    end
    rest = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wb_req, busy, cmd_ready, tag_index, tag_way} !== 6'd0) begin
      miscompares++;
      $display("FAIL midwb_reset: got wb_req=%b busy=%b ready=%b line=%0d, required all 0",
               wb_req, busy, cmd_ready, {tag_index, tag_way});
    end
    exp_wr_q.delete();
    exp_wb_q.delete();
    rest = 1'b1;
    @(negedge clk);
    run_walk(2'b01, 0, 0, 2'b00, 1'b0, ready_cyc, ready_cnt, busy_cyc, rd_cnt, wr_cnt, wb_cyc, first_rd, stall_ok, timed_out);
    vectors++;
    if (first_rd !== 3'd0 || timed_out || ready_cyc !== 25) begin
      miscompares++;
      $display("FAIL midwb_restart: got first line %0d ready %0d, required line 0 ready 25", first_rd, ready_cyc);
    end
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_nop();
    test_invalidate();
    test_flush();
    test_flush_inval();
    test_reset_mid_wb();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_wr_q.size() != 0 || exp_wb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d writes %0d wbs pending, required 0 0", exp_wr_q.size(), exp_wb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
